// File: rtl/universal_shift_reg_if.sv
// Purpose : bundles the operation controls, data and status of universal_shift_reg.
// Latency : none, the interface holds only wires.
// Backpressure: none; busy tells the driver when en/mode/d/sil are being ignored.
//
// Signals (master drives controls, slave drives status):
//   en      operation enable (0 = hold)
//   mode    3-bit operation select
//   d       WIDTH-bit parallel load / serialize data
//   sil     serial in at q[0] on shift left
//   sir     serial in at q[WIDTH-1] on shift right and during serialize
//   q       register contents
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   busy    serialize in progress
//   done    one-cycle pulse after the last serialized bit
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sil;
    logic             sir;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sil, sir,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, d, sil, sir,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Purpose : WIDTH-bit universal shift register (load/shift/rotate/asr) with an LSB-first serializer.
// Latency : every operation lands on q at the sampling edge; serialize holds busy for WIDTH cycles.
// Backpressure: while busy the controls are ignored; a new start is accepted in the done cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (q = RESET_VAL, busy/done cleared)
//   bus    universal_shift_reg_if.slave: en, mode, d, sil, sir in; q, sout_l, sout_r, busy, done out
//
// Mode encoding: 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 110 asr, 111 serialize.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    universal_shift_reg_if.slave bus
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_SER  = 3'b111;

    // Bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SER  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] q_nxt;

    // Next register value for an idle, enabled cycle. Serialize start loads d
    // exactly like a parallel load; the state change is handled below.
    always_comb begin
        q_nxt = q_r;
        case (bus.mode)
            MODE_HOLD: q_nxt = q_r;
            MODE_LOAD: q_nxt = bus.d;
            MODE_SHL:  q_nxt = {q_r[WIDTH-2:0], bus.sil};
            MODE_SHR:  q_nxt = {bus.sir, q_r[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            MODE_ROR:  q_nxt = {q_r[0], q_r[WIDTH-1:1]};
            MODE_ASR:  q_nxt = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            MODE_SER:  q_nxt = bus.d;
            default:   q_nxt = q_r;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            q_r    <= RESET_VAL;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // done is a single-cycle pulse; any idle edge retires it,
                    // including the one that accepts a back-to-back start.
                    done_r <= 1'b0;
                    if (bus.en) begin
                        q_r <= q_nxt;
                        if (bus.mode == MODE_SER) begin
                            state  <= ST_SER;
                            busy_r <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                end
                ST_SER: begin
                    // q[0] already shows the current bit; shifting exposes the next one.
                    q_r <= {bus.sir, q_r[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        done_r <= 1'b0;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.q      = q_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  operation enable; en=0 means hold.
REQ-006 mode  input  3  operation select: 000 hold, 001 parallel load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 arithmetic shift right, 111 serialize start.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sil  input  1  serial input inserted at q[0] on shift left.
REQ-009 sir  input  1  serial input inserted at q[WIDTH-1] on shift right and during serialize.
REQ-010 q  output  WIDTH  register contents.
REQ-011 sout_l  output  1  combinational q[WIDTH-1].
REQ-012 sout_r  output  1  combinational q[0].
REQ-013 busy  output  1  high while a serialize operation is in progress.
REQ-014 done  output  1  one-cycle pulse at serialize completion.

Function
REQ-015 When idle (busy=0) with en=1, at each rising edge q SHALL update per mode: load q=d; shl q={q[WIDTH-2:0],sil}; shr q={sir,q[WIDTH-1:1]}; rol/ror rotate by one bit; asr q={q[WIDTH-1],q[WIDTH-1:1]}; 000 q unchanged.
REQ-016 When idle with en=0, q SHALL hold regardless of mode.
REQ-017 All register ops SHALL take effect at the rising edge where sampled (one-cycle latency), and SHALL be visible on q, sout_l and sout_r immediately afterwards.
REQ-018 Serialize start (idle, en=1, mode=111) SHALL, at that edge: load q=d, set busy=1, clear internal bit counter to 0, keep done=0.
REQ-019 While busy, each rising edge SHALL shift right (q={sir,q[WIDTH-1:1]}) and increment the counter; en, mode, d and sil SHALL be ignored.
REQ-020 d[0]..d[WIDTH-1] SHALL appear on sout_r in the WIDTH consecutive cycles following the start edge, LSB first.
REQ-021 At the busy edge where the counter equals WIDTH-1, busy SHALL clear and done SHALL assert for exactly that one following cycle; busy is therefore high for exactly WIDTH cycles.
REQ-022 A serialize start sampled in the same cycle done is high SHALL be accepted (back-to-back serialize allowed; busy re-asserts with no idle gap beyond the done cycle).
REQ-023 Counter width SHALL be ceil(log2(WIDTH)) bits; no wrap-around shall occur within one operation.
REQ-024 done SHALL be 0 in every cycle other than the completion cycle.

Reset
REQ-025 reset=1 SHALL asynchronously force q=RESET_VAL, busy=0, done=0, counter=0, independent of clk.
REQ-026 reset asserted mid-serialize SHALL abort it with no done pulse; first operation after reset release SHALL be sampled at the first rising edge with reset=0.

Verification (WIDTH=8, RESET_VAL=0)
REQ-027 Assert reset between clock edges -> q=0x00, busy=0, done=0 before next edge; load d=0xA5 after release -> q=0xA5 next edge.
REQ-028 q=0x81, shl sil=0 -> 0x02; rol from 0x81 -> 0x03; ror from 0x81 -> 0xC0; asr from 0x81 -> 0xC0; shr sir=0 from 0x81 -> 0x40.
REQ-029 q=0x3C, en=0 with mode=001, d=0xFF for 3 cycles -> q stays 0x3C.
REQ-030 Serialize d=0xB4, sir=0 -> sout_r sequence 0,0,1,0,1,1,0,1 over 8 cycles, busy high 8 cycles, done one pulse, q=0x00 after; mode changes during busy ignored.
REQ-031 Serialize start again in done cycle with d=0x01 -> busy re-asserts next edge, sout_r=1 then seven 0s.
REQ-032 reset pulse on 4th busy cycle -> q=0x00, busy=0, no done pulse.
